// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port arbitrated RAM.
package ram_arb_pkg;

  localparam int RAM_ARB_ADDR_W = 11;
  localparam int RAM_ARB_DATA_W = 16;
  localparam int CELL_ADDR_W    = 11;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/SB_RAM2048x2.sv
// Behavioural stand-in for the iCE40 SB_RAM2048x2 block RAM primitive.
// Leave this file out of the build when the vendor cell library provides it.
module SB_RAM2048x2 (
  output logic [1:0]  RDATA,
  input  logic [10:0] RADDR,
  input  logic        RCLK,
  input  logic        RCLKE,
  input  logic        RE,
  input  logic [10:0] WADDR,
  input  logic        WCLK,
  input  logic        WCLKE,
  input  logic [1:0]  WDATA,
  input  logic        WE
);

  logic [1:0] mem [0:2047];

  always_ff @(posedge WCLK) begin
    if (WCLKE && WE) mem[WADDR] <= WDATA;
  end

  // Output register holds its value whenever the read port is not enabled.
  always_ff @(posedge RCLK) begin
    if (RCLKE && RE) RDATA <= mem[RADDR];
  end

endmodule

// File: rtl/ram_arb_bank.sv
// Word-wide memory bank built from 2-bit SB_RAM2048x2 cells; cell k stores bits [2k+1:2k].
module ram_arb_bank
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ARB_ADDR_W,
  parameter int DATA_W = RAM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [CELL_ADDR_W-1:0] cell_waddr;
  logic [CELL_ADDR_W-1:0] cell_raddr;

  assign cell_waddr = CELL_ADDR_W'(waddr);
  assign cell_raddr = CELL_ADDR_W'(raddr);

  for (genvar k = 0; k < DATA_W / 2; k++) begin : g_cell
    SB_RAM2048x2 u_cell (
      .RDATA (rdata[2*k+1:2*k]),
      .RADDR (cell_raddr),
      .RCLK  (clk),
      .RCLKE (1'b1),
      .RE    (re),
      .WADDR (cell_waddr),
      .WCLK  (clk),
      .WCLKE (1'b1),
      .WDATA (wdata[2*k+1:2*k]),
      .WE    (we)
    );
  end

endmodule

// File: rtl/ram_arb_2p.sv
// Two-port round-robin arbiter in front of a single-port-pair RAM bank.
// Define RAM_ARB_CLEAR_EN to zero the whole memory after every reset.
module ram_arb_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ARB_ADDR_W,
  parameter int DATA_W = RAM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata
);

  state_e            state, state_nxt;
  port_e             prio, winner;
  logic              both, any_gnt, gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              rd_a_q, rd_b_q, data_seen;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
`ifdef RAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef RAM_ARB_CLEAR_EN
      ST_RESET: state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
`else
      ST_RESET: state_nxt = ST_RUN;
      ST_CLEAR: state_nxt = ST_RUN;
`endif
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // rst gates ready directly so nothing is granted during the reset cycle itself.
  assign ready = (state == ST_RUN) && !rst;

  always_comb begin
    both = a_req && b_req;
    if (both)       winner = prio;
    else if (a_req) winner = PORT_A;
    else            winner = PORT_B;
    a_gnt     = ready && a_req && (winner == PORT_A);
    b_gnt     = ready && b_req && (winner == PORT_B);
    any_gnt   = a_gnt || b_gnt;
    gnt_we    = (winner == PORT_A) ? a_we    : b_we;
    gnt_addr  = (winner == PORT_A) ? a_addr  : b_addr;
    gnt_wdata = (winner == PORT_A) ? a_wdata : b_wdata;
  end

  always_comb begin
    ram_we    = any_gnt && gnt_we;
    ram_re    = any_gnt && !gnt_we;
    ram_waddr = gnt_addr;
    ram_wdata = gnt_wdata;
`ifdef RAM_ARB_CLEAR_EN
    if ((state == ST_CLEAR) && !rst) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
`endif
  end

`ifdef RAM_ARB_CLEAR_EN
  assign clr_last = (clr_addr == '1);

  always_ff @(posedge clk) begin
    if (rst)                    clr_addr <= '0;
    else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
  end
`endif

  // The pointer flips only on a granted conflict, away from the port just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= PORT_A;
      rd_a_q    <= 1'b0;
      rd_b_q    <= 1'b0;
      data_seen <= 1'b0;
    end else begin
      if (both && any_gnt) prio <= (winner == PORT_A) ? PORT_B : PORT_A;
      rd_a_q <= a_gnt && !a_we;
      rd_b_q <= b_gnt && !b_we;
      if (ram_re) data_seen <= 1'b1;
    end
  end

  // The RAM output register cannot be reset, so rdata reads as zero until the first read.
  assign rdata    = data_seen ? ram_rdata : '0;
  assign a_rvalid = rd_a_q && !rst;
  assign b_rvalid = rd_b_q && !rst;

  ram_arb_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (gnt_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ram_arb_2p.sv
// Scoreboard bench for ram_arb_2p: directed requests push expected reads, a monitor pops them.
`timescale 1ns/1ps
module tb_ram_arb_2p;
  import ram_arb_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
`ifdef RAM_ARB_CLEAR_EN
  localparam int          EXP_LOW = 2048;
  localparam logic [15:0] EXP_10  = 16'h0000;
`else
  localparam int          EXP_LOW = 0;
  localparam logic [15:0] EXP_10  = 16'h1111;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, rdata;

  ram_arb_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ar, input logic aw, input logic [10:0] aa, input logic [15:0] ad,
                                input logic br, input logic bw, input logic [10:0] ba, input logic [15:0] bd);
    @(posedge clk); #1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
  endtask

  task automatic expect_read(input logic port, input logic [15:0] data);
    exp_q.push_back('{port, data, cyc + 1});
  endtask

  // Releases rst with requests held; returns at the first negedge that shows ready=1.
  task automatic release_and_wait(input int exp_low);
    int low;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_release_cycle", ready, 0);
    check_output("gnt_release_cycle", {a_gnt, b_gnt}, 0);
    low = 0;
    forever begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ready || low >= 3000) break;
      check_output("gnt_while_not_ready", {a_gnt, b_gnt}, 0);
      low++;
    end
    check_output("ready_low_cycles", low, exp_low);
  endtask

  always @(negedge clk) begin
    if (!done && (a_rvalid || b_rvalid)) begin
      check_output("rvalid_exclusive", a_rvalid && b_rvalid, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got a_rvalid=%0b b_rvalid=%0b, expected none", a_rvalid, b_rvalid);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("rvalid_port", b_rvalid, mon_e.port);
        check_output("rdata", rdata, mon_e.data);
        check_output("rvalid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'h030; a_wdata = 16'hAAAA;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0;     b_wdata = '0;
    repeat (2) @(negedge clk);
    check_output("reset_ready", ready, 0);
    check_output("reset_gnt", {a_gnt, b_gnt}, 0);
    check_output("reset_rvalid", {a_rvalid, b_rvalid}, 0);
    check_output("reset_rdata", rdata, 0);

    // Write held through reset is granted on the first ready cycle
    release_and_wait(EXP_LOW);
    check_output("first_ready_gnt_a", a_gnt, 1);
    apply_stimulus(1'b1, 1'b0, 11'h030, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("read30_gnt", a_gnt, 1);
    expect_read(PORT_A, 16'hAAAA);

    // A writes 0xBEEF to 0x005 then reads it back
    apply_stimulus(1'b1, 1'b1, 11'h005, 16'hBEEF, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("wr5_gnt", {a_gnt, b_gnt}, 2'b10);
    apply_stimulus(1'b1, 1'b0, 11'h005, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("rd5_gnt", {a_gnt, b_gnt}, 2'b10);
    expect_read(PORT_A, 16'hBEEF);

    apply_stimulus(1'b1, 1'b1, 11'h010, 16'h1111, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("wr10_gnt", a_gnt, 1);
    apply_stimulus(1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b1, 11'h011, 16'h2222);
    check_output("wr11_gnt", {a_gnt, b_gnt}, 2'b01);

    // B write followed immediately by A read of the same address
    apply_stimulus(1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b1, 11'h7FF, 16'h1234);
    check_output("wr7ff_gnt", {a_gnt, b_gnt}, 2'b01);
    apply_stimulus(1'b1, 1'b0, 11'h7FF, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("rd7ff_gnt", {a_gnt, b_gnt}, 2'b10);
    expect_read(PORT_A, 16'h1234);
    idle();

    // Both ports read continuously: grants alternate starting with A
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b0, 11'h010, 16'h0, 1'b1, 1'b0, 11'h011, 16'h0);
      if (i % 2 == 0) begin
        check_output("rr_gnt", {a_gnt, b_gnt}, 2'b10);
        expect_read(PORT_A, 16'h1111);
      end else begin
        check_output("rr_gnt", {a_gnt, b_gnt}, 2'b01);
        expect_read(PORT_B, 16'h2222);
      end
    end
    idle();
    idle();
    check_output("rdata_hold", rdata, 16'h2222);

    // Reset the cycle after a granted read: that read never completes
    apply_stimulus(1'b1, 1'b0, 11'h005, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("rst_read_gnt", a_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
    @(negedge clk);
    check_output("rst_ready", ready, 0);
    check_output("rst_gnt", {a_gnt, b_gnt}, 0);
    check_output("rst_rvalid_dropped", a_rvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst_ready_2", ready, 0);
    check_output("rst_rvalid_2", {a_rvalid, b_rvalid}, 0);
    check_output("rst_rdata", rdata, 0);
    release_and_wait(EXP_LOW);
    check_output("post_rst_gnt", {a_gnt, b_gnt}, 2'b10);
    expect_read(PORT_A, EXP_10);
    idle();

`ifdef RAM_ARB_CLEAR_EN
    // Clear after reset wipes a preloaded word
    apply_stimulus(1'b1, 1'b1, 11'h100, 16'hFFFF, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("wr100_gnt", a_gnt, 1);
    apply_stimulus(1'b1, 1'b0, 11'h100, 16'h0, 1'b0, 1'b0, 11'h0, 16'h0);
    check_output("rd100_gnt", a_gnt, 1);
    expect_read(PORT_A, 16'hFFFF);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h100;
    @(negedge clk);
    check_output("clr_rst_ready", ready, 0);
    release_and_wait(2048);
    check_output("clr_rd100_gnt", a_gnt, 1);
    expect_read(PORT_A, 16'h0000);
    idle();
`endif

    idle();
    idle();
    check_output("scoreboard_empty", exp_q.size(), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
